// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle multiply/divide unit for the E stage. Owns the HI/LO register
// pair and raises a registered busy flag while an operation is in flight so
// the D-stage stall unit can hold further md instructions.
//
// The result is computed when the op is accepted and parked in pending
// registers. HI/LO keep their old values until the full latency has elapsed
// and are only then overwritten, so no partial results are ever visible.
//
// Parameters:
//   MULT_CYCLES - busy cycles for mult/multu (and madd family), >= 1
//   DIV_CYCLES  - busy cycles for div/divu, >= 1
//
// Ports:
//   clk    in   1  clock, rising edge
//   reset  in   1  asynchronous, active-high reset
//   start  in   1  E-stage md op valid this cycle
//   op     in   4  0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo,
//                  6 madd,7 maddu,8 msub,9 msubu
//   A      in  32  forwarded rs value
//   B      in  32  forwarded rt value
//   busy   out  1  registered, high while a mult/div is in flight
//   HI     out 32  HI register
//   LO     out 32  LO register
//
// Build option:
//   MDU_MADD_EN - when defined, ops 6..9 (multiply-accumulate/subtract on
//                 {HI,LO}) are supported; otherwise they are undefined ops.
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic          r_pend_wr;

  // Decode / control strobes
  logic          w_is_mul;
  logic          w_is_div;
  logic          w_is_mthi;
  logic          w_is_mtlo;
  logic          w_signed;
  logic          w_idle;
  logic          w_launch;
  logic          w_done;
  logic [CW-1:0] w_load_val;
`ifdef MDU_MADD_EN
  logic          w_is_acc;
  logic          w_acc_sub;
  logic [63:0]   w_hilo;
`endif

  // Datapath
  logic [63:0]   w_a_ext;
  logic [63:0]   w_b_ext;
  logic [63:0]   w_prod;
  logic [63:0]   w_mul_res;
  logic          w_neg_a;
  logic          w_neg_b;
  logic [31:0]   w_abs_a;
  logic [31:0]   w_abs_b;
  logic [31:0]   w_div_b;
  logic [31:0]   w_q_mag;
  logic [31:0]   w_r_mag;
  logic [31:0]   w_quot;
  logic [31:0]   w_rem;

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

  // ---------------------------------------------------------------- decode
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_is_mul  = 1'b0;
    w_is_div  = 1'b0;
    w_is_mthi = 1'b0;
    w_is_mtlo = 1'b0;
    w_signed  = 1'b0;
`ifdef MDU_MADD_EN
    w_is_acc  = 1'b0;
    w_acc_sub = 1'b0;
`endif
    case (op)
      OP_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      OP_MULTU: w_is_mul = 1'b1;
      OP_DIV:   begin w_is_div = 1'b1; w_signed = 1'b1; end
      OP_DIVU:  w_is_div = 1'b1;
      OP_MTHI:  w_is_mthi = 1'b1;
      OP_MTLO:  w_is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin w_is_mul = 1'b1; w_is_acc = 1'b1; w_signed = 1'b1; end
      OP_MADDU: begin w_is_mul = 1'b1; w_is_acc = 1'b1; end
      OP_MSUB:  begin w_is_mul = 1'b1; w_is_acc = 1'b1; w_acc_sub = 1'b1; w_signed = 1'b1; end
      OP_MSUBU: begin w_is_mul = 1'b1; w_is_acc = 1'b1; w_acc_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- multiply
  // Sign- or zero-extend to 64 bits; the low 64 bits of the 64x64 product are
  // the correct 32x32 product for both signednesses.
  assign w_a_ext = {{32{w_signed & A[31]}}, A};
  assign w_b_ext = {{32{w_signed & B[31]}}, B};
  assign w_prod  = w_a_ext * w_b_ext;

`ifdef MDU_MADD_EN
  // Accumulation uses HI/LO as they stand on the accepting edge.
  assign w_hilo    = {r_hi, r_lo};
  assign w_mul_res = !w_is_acc ? w_prod :
                     w_acc_sub ? (w_hilo - w_prod) : (w_hilo + w_prod);
`else
  assign w_mul_res = w_prod;
`endif

  // ---------------------------------------------------------------- divide
  // Divide magnitudes, then fix signs: quotient truncates toward zero and the
  // remainder follows the dividend. Working on magnitudes also makes
  // 0x80000000 / -1 wrap cleanly to 0x80000000 with remainder 0.
  assign w_neg_a = w_signed & A[31];
  assign w_neg_b = w_signed & B[31];
  assign w_abs_a = w_neg_a ? (32'd0 - A) : A;
  assign w_abs_b = w_neg_b ? (32'd0 - B) : B;
  // Keep the divider operand non-zero; a zero divisor never commits anyway.
  assign w_div_b = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
  assign w_q_mag = w_abs_a / w_div_b;
  assign w_r_mag = w_abs_a % w_div_b;
  assign w_quot  = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem   = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;

  // ---------------------------------------------------------------- FSM: state register
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next_state = S_RUN;
      S_RUN:   if (w_done)   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  // A start while RUN is ignored, so every strobe is qualified with IDLE.
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_launch   = start & w_idle & (w_is_mul | w_is_div);
    w_done     = (r_state == S_RUN) && (r_cnt == CNT_ONE);
    w_load_val = w_is_div ? DIV_LOAD : MULT_LOAD;
  end

  // ---------------------------------------------------------------- datapath
  // Counter is loaded with N on the accepting edge and reaches 0 exactly N
  // edges later, which is the commit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      r_busy <= (w_next_state == S_RUN);
      if (w_launch) begin
        r_cnt <= w_load_val;
        if (w_is_div) begin
          r_pend_hi <= w_rem;
          r_pend_lo <= w_quot;
          r_pend_wr <= (B != 32'd0);
        end else begin
          r_pend_hi <= w_mul_res[63:32];
          r_pend_lo <= w_mul_res[31:0];
          r_pend_wr <= 1'b1;
        end
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CNT_ONE;
        if (w_done && r_pend_wr) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
      if (start && w_idle && w_is_mthi) r_hi <= A;
      if (start && w_idle && w_is_mtlo) r_lo <= A;
    end
  end

`ifndef SYNTHESIS
  // The stall unit should never present an op while busy; flag it if it does.
  always @(posedge clk) begin
    if (!reset)
      assert (!(start && r_busy))
        else $warning("mult_div_unit: start ignored while busy");
  end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Directed-vector bench for mult_div_unit with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Define MDU_MADD_EN for both DUT and bench to exercise the accumulate ops.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_vec;
  int n_err;

  mult_div_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Starts at a falling edge, ends at the falling edge after busy drops.
  task automatic run_op(input string tag, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = '0; B = '0;
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_hold_hi"}, HI, old_hi);
      check({tag, "_hold_lo"}, LO, old_lo);
      @(negedge clk);
    end
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  // One-cycle op expected to leave busy low (mthi/mtlo/undefined).
  task automatic quick_op(input string tag, input logic [3:0] o, input logic [31:0] a);
    start = 1'b1; op = o; A = a; B = 32'd0;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1. signed multiply -2 * 3 = -6
    run_op("mult", 4'd0, 32'hFFFF_FFFE, 32'd3, MULT_CYCLES,
           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // 2. divu 100 / 7 issued back-to-back with the commit above
    run_op("divu", 4'd3, 32'd100, 32'd7, DIV_CYCLES,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd2, 32'd14);

    // 3. signed divide -7 / 2 -> q=-3, r=-1
    run_op("div_neg", 4'd2, 32'hFFFF_FFF9, 32'd2, DIV_CYCLES,
           32'd2, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    // divide by zero leaves HI/LO alone
    run_op("div_zero", 4'd2, 32'd5, 32'd0, DIV_CYCLES,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    // most-negative / -1 wraps
    run_op("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_CYCLES,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 32'h8000_0000);

    // 4. mthi then mtlo on consecutive cycles
    quick_op("mthi", 4'd4, 32'h1234_5678);
    quick_op("mtlo", 4'd5, 32'd9);
    check("mtx_hi", HI, 32'h1234_5678);
    check("mtx_lo", LO, 32'd9);

    // undefined op: no effect
    quick_op("undef", 4'd12, 32'hDEAD_BEEF);
    @(negedge clk);
    check("undef_busy2", {31'd0, busy}, 32'd0);
    check("undef_hi", HI, 32'h1234_5678);
    check("undef_lo", LO, 32'd9);

    // 5. reset three cycles into a divide
    start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("rst_div_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_post_hi", HI, 32'd0);
    check("rst_post_lo", LO, 32'd0);
    run_op("multu", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_CYCLES,
           32'd0, 32'd0, 32'hFFFF_FFFE, 32'h0000_0001);

    // 6. maddu onto HI=0, LO=0xFFFFFFFF
    quick_op("mthi0", 4'd4, 32'd0);
    quick_op("mtlo1", 4'd5, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", 4'd7, 32'd1, 32'd1, MULT_CYCLES,
           32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    // msub -2*3 from {1,0}: 0x1_00000000 - (-6) = 0x1_00000006
    run_op("msub", 4'd8, 32'hFFFF_FFFE, 32'd3, MULT_CYCLES,
           32'd1, 32'd0, 32'd1, 32'd6);
`else
    quick_op("maddu_off", 4'd7, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("maddu_off_busy", {31'd0, busy}, 32'd0);
    end
    check("maddu_off_hi", HI, 32'd0);
    check("maddu_off_lo", LO, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
